// File: rtl/prf_pkg.sv
// prf_pkg: shared tag/data types and the hardwired-zero tag for the physical register file.
package prf_pkg;
   localparam int PRF_DATA_W = 32;
   localparam int PRF_PREG_W = 7;
   localparam int PREG_ZERO  = 0;
   typedef logic [PRF_PREG_W-1:0] preg_t;
   typedef logic [PRF_DATA_W-1:0] prf_data_t;
endpackage

// File: rtl/prf_read_port.sv
// prf_read_port: one registered read port with tag-0 masking and, under PRF_BYPASS_EN,
// same-cycle write-to-read forwarding.
module prf_read_port
   import prf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PREG_W = 7,
   parameter int NUM_WR = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           en,
   input  logic [PREG_W-1:0]              ps,
   input  logic [DATA_W-1:0]              arr_data,
   input  logic                           arr_rdy,
   input  logic [NUM_WR-1:0]              wr_en,
   input  logic [NUM_WR-1:0][PREG_W-1:0]  wr_pd,
   input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
   input  logic                           alloc_en,
   input  logic [PREG_W-1:0]              alloc_pd,
   input  logic                           flush,
   output logic [DATA_W-1:0]              data,
   output logic                           rdy,
   output logic                           valid
);
   logic [DATA_W-1:0] data_nxt;
   logic              rdy_nxt;
`ifdef PRF_BYPASS_EN
   logic              hit;
   always_comb begin
      data_nxt = arr_data;
      rdy_nxt  = arr_rdy;
      hit      = 1'b0;
      for (int j = 0; j < NUM_WR; j++)
         if (wr_en[j] && wr_pd[j] == ps) begin
            data_nxt = wr_data[j];
            rdy_nxt  = 1'b1;
            hit      = 1'b1;
         end
      // a same-cycle alloc of the forwarded tag leaves it not-ready unless flush overrides
      if (hit && alloc_en && alloc_pd == ps && !flush) rdy_nxt = 1'b0;
      if (ps == PREG_W'(PREG_ZERO)) begin
         data_nxt = '0;
         rdy_nxt  = 1'b1;
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{wr_en, wr_pd, wr_data, alloc_en, alloc_pd, flush};
   always_comb begin
      data_nxt = (ps == PREG_W'(PREG_ZERO)) ? '0 : arr_data;
      rdy_nxt  = (ps == PREG_W'(PREG_ZERO)) ? 1'b1 : arr_rdy;
   end
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data  <= '0;
         rdy   <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= en;
         if (en) begin
            data <= data_nxt;
            rdy  <= rdy_nxt;
         end
      end
   end
endmodule

// File: rtl/prf_multiport.sv
// prf_multiport: multi-ported physical register file with per-tag ready bits.
// Define PRF_BYPASS_EN to forward same-cycle writeback data to reads.
module prf_multiport
   import prf_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int NUM_PREGS = 128,
   parameter int NUM_RD    = 6,
   parameter int NUM_WR    = 2
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [NUM_WR-1:0]                           wr_en,
   input  logic [NUM_WR-1:0][$clog2(NUM_PREGS)-1:0]    wr_pd,
   input  logic [NUM_WR-1:0][DATA_W-1:0]               wr_data,
   input  logic                                        alloc_en,
   input  logic [$clog2(NUM_PREGS)-1:0]                alloc_pd,
   input  logic                                        flush,
   input  logic [NUM_RD-1:0]                           rd_en,
   input  logic [NUM_RD-1:0][$clog2(NUM_PREGS)-1:0]    rd_ps,
   output logic [NUM_RD-1:0][DATA_W-1:0]               rd_data,
   output logic [NUM_RD-1:0]                           rd_valid,
   output logic [NUM_RD-1:0]                           rd_rdy
);
   localparam int PREG_W = $clog2(NUM_PREGS);
   logic [DATA_W-1:0]    mem [NUM_PREGS];
   logic [NUM_PREGS-1:0] rdy, rdy_nxt;
   // writes set ready, alloc then clears it, flush overrides both; tag 0 stays ready
   always_comb begin
      rdy_nxt = rdy;
      for (int j = 0; j < NUM_WR; j++)
         if (wr_en[j]) rdy_nxt[wr_pd[j]] = 1'b1;
      if (alloc_en) rdy_nxt[alloc_pd] = 1'b0;
      if (flush) rdy_nxt = '1;
      rdy_nxt[PREG_W'(PREG_ZERO)] = 1'b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdy <= '1;
      else rdy <= rdy_nxt;
   end
   // ascending port order lets the highest-index writer win on a shared tag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_PREGS; k++) mem[k] <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && wr_pd[j] != PREG_W'(PREG_ZERO)) mem[wr_pd[j]] <= wr_data[j];
      end
   end
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      prf_read_port #(
         .DATA_W (DATA_W),
         .PREG_W (PREG_W),
         .NUM_WR (NUM_WR)
      ) u_port (
         .clk      (clk),
         .reset    (reset),
         .en       (rd_en[g]),
         .ps       (rd_ps[g]),
         .arr_data (mem[rd_ps[g]]),
         .arr_rdy  (rdy[rd_ps[g]]),
         .wr_en    (wr_en),
         .wr_pd    (wr_pd),
         .wr_data  (wr_data),
         .alloc_en (alloc_en),
         .alloc_pd (alloc_pd),
         .flush    (flush),
         .data     (rd_data[g]),
         .rdy      (rd_rdy[g]),
         .valid    (rd_valid[g])
      );
   end
endmodule
